// File: rtl/mau_pkg.sv
// Shared constants, state encoding and the alignment rule for mem_access_unit.
package mau_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } mau_state_e;

    // True when the access must be refused: unaligned half/word, or size 11.
    function automatic logic mau_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mau_load_extend.sv
// Size/sign extender for load data returned right-justified by the RAM.
module mau_load_extend
    import mau_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] data_out
);

    // Pick the low byte/half and fill the upper bits with the sign or zero.
    always_comb begin
        data_out = data_in;
        case (size)
            SIZE_BYTE: data_out = {{(DATA_W-8){sgn & data_in[7]}}, data_in[7:0]};
            SIZE_HALF: data_out = {{(DATA_W-16){sgn & data_in[15]}}, data_in[15:0]};
            default:   data_out = data_in;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving a strobed byte-addressed RAM.
// Optional feature: define MAU_ALIGN_CHECK_EN to refuse misaligned or
// illegal-size requests without touching memory (default: no check).
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_dout
);

    mau_state_e        state_q, state_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              signed_q, signed_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] ext_data;
    logic              req_bad;

`ifdef MAU_ALIGN_CHECK_EN
    assign req_bad = mau_misaligned(req_addr[1:0], req_size);
`else
    assign req_bad = 1'b0;
`endif

    // Extension works straight off the RAM output; the result is registered at
    // the end of CAPTURE, which is where the load data is sampled.
    mau_load_extend #(.DATA_W(DATA_W)) u_ext (
        .data_in  (mem_dout),
        .size     (mem_size_q),
        .sgn      (signed_q),
        .data_out (ext_data)
    );

    // Next-state and registered-output computation for the access sequence.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_size_d   = mem_size_q;
        signed_d     = signed_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        // Refused: respond next cycle, RAM pins keep old values.
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = SETUP;
                        mem_rw_d   = req_rw;
                        mem_addr_d = req_addr;
                        mem_din_d  = req_wdata;
                        mem_size_d = req_size;
                        signed_d   = req_signed;
                    end
                end
            end
            SETUP: begin
                state_d      = STROBE;
                mem_enable_d = 1'b1;
            end
            STROBE:  state_d = CAPTURE;
            CAPTURE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = (mem_rw_q == RW_READ) ? ext_data : '0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= RW_READ;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_size_q   <= SIZE_BYTE;
            signed_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_size_q   <= mem_size_d;
            signed_q     <= signed_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_enable = mem_enable_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_size   = mem_size_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit (build with or without MAU_ALIGN_CHECK_EN).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_size;
    logic [31:0] mem_dout = '0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_size(mem_size), .mem_dout(mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare a DUT response against the oldest scoreboard entry.
    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " spurious_resp"}, 32'(resp_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, " rdata"}, resp_rdata, e.rdata);
            check({tag, " err"}, 32'(resp_err), 32'(e.err));
        end
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
    endtask

    // One request: accept edge N, then observe cycles N+1..N+6.
    task automatic run_req(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                           input logic [31:0] dout, input logic [31:0] exp_rdata,
                           input logic exp_err);
        int en_cnt = 0, en_cyc = 0, rv_cnt = 0, rv_cyc = 0;
        wait_ready(tag);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wdata; mem_dout = dout;
        @(posedge clk);
        sb.push_back('{exp_rdata, exp_err});
        #1 req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_rw = ~rw;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_enable) begin en_cnt++; en_cyc = k; end
            if (resp_valid) begin rv_cnt++; rv_cyc = k; pop_check(tag); end
            if (!exp_err && k <= 3) begin
                check({tag, " mem_addr"}, mem_addr, addr);
                check({tag, " mem_rw"}, 32'(mem_rw), 32'(rw));
                check({tag, " mem_size"}, 32'(mem_size), 32'(size));
                check({tag, " mem_din"}, mem_din, wdata);
            end
        end
        check({tag, " strobes"}, en_cnt, exp_err ? 0 : 1);
        if (!exp_err) check({tag, " strobe_cycle"}, en_cyc, 2);
        check({tag, " resp_count"}, rv_cnt, 1);
        check({tag, " resp_cycle"}, rv_cyc, exp_err ? 1 : 4);
    endtask

    initial begin
        int en_cnt, rv_cnt, en_a, en_b, rv_a, rv_b;

        // Reset state, sampled while reset is held and after release.
        repeat (2) @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst mem_enable", 32'(mem_enable), 32'd0);
        check("rst mem_rw", 32'(mem_rw), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_din", mem_din, 32'd0);
        check("rst mem_size", 32'(mem_size), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst ready", 32'(req_ready), 32'd1);

        // Loads with sign/zero extension and word pass-through.
        run_req("lb_s",  1'b0, 32'd0, 2'b00, 1'b1, 32'h0, 32'h0000_0081, 32'hFFFF_FF81, 1'b0);
        run_req("lb_u",  1'b0, 32'd0, 2'b00, 1'b0, 32'h0, 32'h0000_0081, 32'h0000_0081, 1'b0);
        run_req("lh_s",  1'b0, 32'd2, 2'b01, 1'b1, 32'h0, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
        run_req("lh_u",  1'b0, 32'd2, 2'b01, 1'b0, 32'h0, 32'hABCD_8001, 32'h0000_8001, 1'b0);
        run_req("lb_sp", 1'b0, 32'd1, 2'b00, 1'b1, 32'h0, 32'hFFFF_FF7F, 32'h0000_007F, 1'b0);
        run_req("lw",    1'b0, 32'd4, 2'b10, 1'b1, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0);
        // Store returns zero data even though the RAM output is nonzero.
        run_req("sw",    1'b1, 32'd8, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h9999_9999, 32'h0, 1'b0);

`ifdef MAU_ALIGN_CHECK_EN
        run_req("lh_mis", 1'b0, 32'd3, 2'b01, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        run_req("lw_mis", 1'b0, 32'd6, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        run_req("sz_ill", 1'b1, 32'd0, 2'b11, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        // Refused access must leave RAM pins at the previous good access.
        check("err_hold mem_addr", mem_addr, 32'd8);
`else
        run_req("lh_mis", 1'b0, 32'd3, 2'b01, 1'b0, 32'h0, 32'h0000_1234, 32'h0000_1234, 1'b0);
        run_req("lw_mis", 1'b0, 32'd6, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 32'h1122_3344, 1'b0);
`endif

        // Back-to-back: B held valid while A (store) is busy.
        wait_ready("b2b");
        mem_dout = 32'hCAFE_F00D;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h10; req_size = 2'b10; req_wdata = 32'h0BAD_CAFE;
        @(posedge clk);
        sb.push_back('{32'h0, 1'b0});
        #1 req_rw = 1'b0; req_addr = 32'h14; req_size = 2'b10; req_signed = 1'b0;
        en_cnt = 0; rv_cnt = 0; en_a = 0; en_b = 0; rv_a = 0; rv_b = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 4) check("b2b ready_low", 32'(req_ready), 32'd0);
            if (mem_enable) begin en_cnt++; if (en_a == 0) en_a = k; else en_b = k; end
            if (resp_valid) begin rv_cnt++; if (rv_a == 0) rv_a = k; else rv_b = k; pop_check("b2b"); end
            if (k == 5) begin
                check("b2b ready_back", 32'(req_ready), 32'd1);
                sb.push_back('{32'hCAFE_F00D, 1'b0});
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        check("b2b strobes", en_cnt, 2);
        check("b2b strobe_a", en_a, 2);
        check("b2b strobe_b", en_b, 7);
        check("b2b resp_count", rv_cnt, 2);
        check("b2b resp_a", rv_a, 4);
        check("b2b resp_b", rv_b, 9);

        // Reset asserted during STROBE drops the transaction.
        wait_ready("rst_mid");
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h20; req_size = 2'b00; req_signed = 1'b1;
        mem_dout = 32'h0000_00F0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 check("rst_mid strobe_on", 32'(mem_enable), 32'd1);
        reset = 1'b1;
        #1 check("rst_mid enable_drop", 32'(mem_enable), 32'd0);
        check("rst_mid resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        en_cnt = 0; rv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_enable) en_cnt++;
            if (resp_valid) rv_cnt++;
        end
        check("rst_mid no_strobe", en_cnt, 0);
        check("rst_mid no_resp", rv_cnt, 0);
        check("rst_mid ready", 32'(req_ready), 32'd1);
        run_req("lb_after", 1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
